// File: rtl/sha256_pkg.sv
// Shared types and constants for the single-block SHA-256 message sequencer.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_FEED,
    ST_WAIT,
    ST_OUT
  } state_e;

  localparam int SHA_BLOCK_BYTES   = 64;
  localparam int SHA_DIGEST_BYTES  = 32;
  localparam int SHA_MAX_MSG_BYTES = 55;
  localparam int SHA_LEN_OFFSET    = SHA_BLOCK_BYTES - 8;

  localparam logic [7:0] SHA_PAD_BYTE = 8'h80;

endpackage

// File: rtl/sha256_pad_gen.sv
// Maps a block beat index, message length and buffered byte to the padded SHA-256 byte.
module sha256_pad_gen
  import sha256_pkg::*;
(
  input  logic [5:0] k_i,
  input  logic [5:0] cnt_i,
  input  logic [7:0] buf_byte_i,
  output logic [7:0] pad_byte_o
);

  logic [63:0] len_bits;

  assign len_bits = {55'b0, cnt_i, 3'b000};

  // Beats 56..63 carry the length MSB first, so beat k holds byte (63-k) = ~k[2:0].
  always_comb begin
    pad_byte_o = 8'h00;
    if (k_i < cnt_i) begin
      pad_byte_o = buf_byte_i;
    end else if (k_i == cnt_i) begin
      pad_byte_o = SHA_PAD_BYTE;
    end else if (k_i >= 6'(SHA_LEN_OFFSET)) begin
      pad_byte_o = len_bits[{~k_i[2:0], 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/sha256_block_sequencer.sv
// Buffers a 1-55 byte message, streams its padded block to the hash core, forwards the digest.
// Optional WAIT/OUT watchdog enabled by defining SHA_SEQ_TIMEOUT_EN.
module sha256_block_sequencer
  import sha256_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] core_data,
  output logic       core_valid,
  input  logic [7:0] core_hash,
  input  logic       core_hash_valid,
  output logic [7:0] m_hash,
  output logic       m_valid,
  output logic       m_last,
  output logic       busy,
  output logic       err
);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] k_q, k_d;
  logic [4:0] dig_q, dig_d;
  logic [7:0] m_hash_q, m_hash_d;
  logic       m_valid_q, m_valid_d;
  logic       m_last_q, m_last_d;
  logic       err_q, err_d;
  logic       s_ready_q, core_valid_q, busy_q;
  logic       accept, wr_en;
  logic [5:0] wr_idx;
  logic [7:0] buf_q [SHA_MAX_MSG_BYTES];
  logic [7:0] buf_rd, pad_byte;

`ifdef SHA_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  assign accept = s_valid && s_ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    dig_d     = dig_q;
    m_hash_d  = m_hash_q;
    m_valid_d = 1'b0;
    m_last_d  = 1'b0;
    err_d     = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = cnt_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        wr_en   = 1'b1;
        wr_idx  = 6'd0;
        cnt_d   = 6'd1;
        k_d     = 6'd0;
        state_d = s_last ? ST_FEED : ST_LOAD;
      end
      ST_LOAD: if (accept) begin
        // A 56th byte can never fit alongside the 0x80 marker and length field.
        if (cnt_q == 6'(SHA_MAX_MSG_BYTES)) begin
          err_d   = 1'b1;
          state_d = s_last ? ST_IDLE : ST_DRAIN;
        end else begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 6'd1;
          if (s_last) begin
            k_d     = 6'd0;
            state_d = ST_FEED;
          end
        end
      end
      ST_DRAIN: if (accept && s_last) state_d = ST_IDLE;
      ST_FEED: begin
        k_d = k_q + 6'd1;
        if (k_q == 6'(SHA_BLOCK_BYTES - 1)) state_d = ST_WAIT;
      end
      ST_WAIT: if (core_hash_valid) begin
        m_hash_d  = core_hash;
        m_valid_d = 1'b1;
        dig_d     = 5'd1;
        state_d   = ST_OUT;
      end
      ST_OUT: if (core_hash_valid) begin
        m_hash_d  = core_hash;
        m_valid_d = 1'b1;
        dig_d     = dig_q + 5'd1;
        if (dig_q == 5'(SHA_DIGEST_BYTES - 1)) begin
          m_last_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef SHA_SEQ_TIMEOUT_EN
    tmo_d = '0;
    if ((state_q == ST_WAIT || state_q == ST_OUT) && !core_hash_valid) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      k_q          <= '0;
      dig_q        <= '0;
      m_hash_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      err_q        <= 1'b0;
      s_ready_q    <= 1'b0;
      core_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SHA_SEQ_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      k_q          <= k_d;
      dig_q        <= dig_d;
      m_hash_q     <= m_hash_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      err_q        <= err_d;
      s_ready_q    <= (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_DRAIN);
      core_valid_q <= (state_d == ST_FEED);
      busy_q       <= (state_d != ST_IDLE);
`ifdef SHA_SEQ_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  // Message storage carries no reset; only bytes below cnt are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_idx] <= s_data;
  end

  assign buf_rd = (k_q < 6'(SHA_MAX_MSG_BYTES)) ? buf_q[k_q] : 8'h00;

  sha256_pad_gen u_pad_gen (
    .k_i        (k_q),
    .cnt_i      (cnt_q),
    .buf_byte_i (buf_rd),
    .pad_byte_o (pad_byte)
  );

  assign s_ready    = s_ready_q;
  assign core_valid = core_valid_q;
  assign core_data  = core_valid_q ? pad_byte : 8'h00;
  assign m_hash     = m_hash_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Directed plus randomized bench for sha256_block_sequencer; the bench itself plays the hash core.
// The watchdog scenario runs only when SHA_SEQ_TIMEOUT_EN is defined.
module tb_sha256_block_sequencer;

`ifdef SHA_SEQ_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`else
  localparam int unsigned TMO = 1024;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic [7:0] core_data;
  logic       core_valid;
  logic [7:0] core_hash = 8'h00;
  logic       core_hash_valid = 1'b0;
  logic [7:0] m_hash;
  logic       m_valid;
  logic       m_last;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] msg_q[$];
  logic [7:0] dig_a[32];
  logic [7:0] cv_q[$];
  int         cv_cyc[$];
  logic [7:0] m_q[$];
  int         m_cyc[$];
  logic       ml_q[$];
  int         hv_cyc[$];
  int         err_cyc[$];
  int         acc_cyc[$];

  sha256_block_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_last          (s_last),
    .s_ready         (s_ready),
    .core_data       (core_data),
    .core_valid      (core_valid),
    .core_hash       (core_hash),
    .core_hash_valid (core_hash_valid),
    .m_hash          (m_hash),
    .m_valid         (m_valid),
    .m_last          (m_last),
    .busy            (busy),
    .err             (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor, sampling away from the active edge.
  always @(negedge clk) begin
    if (core_valid) begin cv_q.push_back(core_data); cv_cyc.push_back(cyc); end
    if (m_valid) begin m_q.push_back(m_hash); m_cyc.push_back(cyc); ml_q.push_back(m_last); end
    if (core_hash_valid) hv_cyc.push_back(cyc);
    if (err) err_cyc.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed hang, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    cv_q.delete(); cv_cyc.delete(); m_q.delete(); m_cyc.delete(); ml_q.delete();
    hv_cyc.delete(); err_cyc.delete(); acc_cyc.delete();
  endtask

  task automatic send_msg(input int gap_max, output int max_wait);
    max_wait = 0;
    for (int i = 0; i < msg_q.size(); i++) begin
      int w;
      w = 0;
      s_data  = msg_q[i];
      s_valid = 1'b1;
      s_last  = (i == msg_q.size() - 1);
      @(negedge clk);
      while (!s_ready && w < 50) begin w++; @(negedge clk); end
      if (w > max_wait) max_wait = w;
      acc_cyc.push_back(cyc);
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_cv(input int n);
    int g;
    g = 0;
    while (cv_q.size() < n && g < 300) begin @(negedge clk); #1; g++; end
  endtask

  task automatic drive_digest(input int gap);
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      core_hash       = dig_a[i];
      core_hash_valid = 1'b1;
      @(posedge clk); #1;
      core_hash_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic run_msg(input string tag, input int host_gap, input int hv_gap);
    logic [7:0]  blk[$];
    logic [63:0] len_bits;
    int mw, last_cyc, n_last;
    clear_mon();
    send_msg(host_gap, mw);
    last_cyc = acc_cyc[acc_cyc.size() - 1];
    // Reference block: message, 0x80, zeros up to byte 56, 64-bit big-endian bit length.
    blk = msg_q;
    blk.push_back(8'h80);
    while (blk.size() < 56) blk.push_back(8'h00);
    len_bits = 64'(msg_q.size()) * 64'd8;
    for (int b = 7; b >= 0; b--) blk.push_back(8'(len_bits >> (8 * b)));
    wait_cv(64);
    check({tag, " beat_count"}, cv_q.size(), 64);
    if (cv_q.size() == 64) begin
      check({tag, " first_beat_cycle"}, cv_cyc[0], last_cyc + 1);
      check({tag, " last_beat_cycle"}, cv_cyc[63], last_cyc + 64);
      for (int b = 0; b < 64; b++)
        check($sformatf("%s beat%0d", tag, b), cv_q[b], blk[b]);
    end
    drive_digest(hv_gap);
    repeat (3) begin @(posedge clk); #1; end
    check({tag, " digest_count"}, m_q.size(), 32);
    if (m_q.size() == 32 && hv_cyc.size() == 32) begin
      n_last = 0;
      for (int i = 0; i < 32; i++) begin
        check($sformatf("%s m_hash%0d", tag, i), m_q[i], dig_a[i]);
        check($sformatf("%s m_latency%0d", tag, i), m_cyc[i], hv_cyc[i] + 1);
        if (ml_q[i]) n_last++;
      end
      check({tag, " m_last_count"}, n_last, 1);
      check({tag, " m_last_pos"}, ml_q[31], 1'b1);
    end
    check({tag, " no_err"}, err_cyc.size(), 0);
    check({tag, " host_no_stall"}, mw, 0);
    check({tag, " idle_busy"}, busy, 1'b0);
    check({tag, " idle_sready"}, s_ready, 1'b1);
    $display("[%0t] msg %s len=%0d beats=%0d digest_beats=%0d", $time, tag, msg_q.size(), cv_q.size(), m_q.size());
  endtask

  task automatic rand_msg(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
    for (int i = 0; i < 32; i++) dig_a[i] = 8'($urandom);
  endtask

  initial begin
    int mw;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sready", s_ready, 1'b0);
    check("rst_core_valid", core_valid, 1'b0);
    check("rst_core_data", core_data, 8'h00);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_m_hash", m_hash, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    reset_n = 1'b1;
    #1 check("rst_release_sready_low", s_ready, 1'b0);
    @(posedge clk); #1;
    check("first_cycle_sready", s_ready, 1'b1);

    // Stray core_hash_valid while idle is ignored
    clear_mon();
    core_hash = 8'h5a; core_hash_valid = 1'b1;
    @(posedge clk); #1;
    core_hash_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("stray_hv_no_m_valid", m_q.size(), 0);
    check("stray_hv_idle", busy, 1'b0);

    // "abc" with the known SHA-256 digest returned by the stand-in core
    msg_q = '{8'h61, 8'h62, 8'h63};
    dig_a = '{8'hba, 8'h78, 8'h16, 8'hbf, 8'h8f, 8'h01, 8'hcf, 8'hea,
              8'h41, 8'h41, 8'h40, 8'hde, 8'h5d, 8'hae, 8'h22, 8'h23,
              8'hb0, 8'h03, 8'h61, 8'ha3, 8'h96, 8'h17, 8'h7a, 8'h9c,
              8'hb4, 8'h10, 8'hff, 8'h61, 8'hf2, 8'h00, 8'h15, 8'had};
    run_msg("abc", 0, 0);

    // Maximum-length message: length field 440 bits = 0x01B8
    rand_msg(55);
    run_msg("len55", 0, 1);
    if (cv_q.size() == 64) begin
      check("len55 pad_at_55", cv_q[55], 8'h80);
      check("len55 len_hi", cv_q[62], 8'h01);
      check("len55 len_lo", cv_q[63], 8'hb8);
    end

    // Overlength: 56 bytes without last, then 3 more ending with last
    msg_q.delete();
    for (int i = 0; i < 59; i++) msg_q.push_back(8'($urandom));
    clear_mon();
    send_msg(0, mw);
    repeat (4) begin @(posedge clk); #1; end
    check("ovl_err_pulses", err_cyc.size(), 1);
    if (err_cyc.size() >= 1) check("ovl_err_cycle", err_cyc[0], acc_cyc[55] + 1);
    check("ovl_no_core_valid", cv_q.size(), 0);
    check("ovl_sready_held", mw, 0);
    check("ovl_idle_busy", busy, 1'b0);
    check("ovl_idle_sready", s_ready, 1'b1);
    $display("[%0t] msg overlength len=59 err_pulses=%0d beats=%0d", $time, err_cyc.size(), cv_q.size());

    // 1-byte message, digest delivered with 2-cycle gaps
    rand_msg(1);
    run_msg("len1_gap2", 3, 2);

    // Random lengths and gaps
    for (int r = 0; r < 4; r++) begin
      rand_msg($urandom_range(55, 1));
      run_msg($sformatf("rand%0d", r), $urandom_range(2, 0), $urandom_range(3, 0));
    end

    // Reset during beat 30 of FEED
    rand_msg(10);
    clear_mon();
    send_msg(0, mw);
    wait_cv(31);
    check("mid_rst_reached_beat30", cv_q.size(), 31);
    reset_n = 1'b0;
    #1;
    check("mid_rst_core_valid", core_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_sready", s_ready, 1'b0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_recover_sready", s_ready, 1'b1);
    check("mid_rst_recover_core_valid", core_valid, 1'b0);
    $display("[%0t] msg reset_mid_feed len=10 beats_before_reset=%0d", $time, cv_q.size());
    rand_msg($urandom_range(20, 2));
    run_msg("after_rst", 1, 0);

`ifdef SHA_SEQ_TIMEOUT_EN
    // Silent core: watchdog abort after TMO idle WAIT cycles
    begin
      int last_beat, g;
      rand_msg(5);
      clear_mon();
      send_msg(0, mw);
      wait_cv(64);
      check("tmo_beat_count", cv_q.size(), 64);
      last_beat = (cv_cyc.size() > 0) ? cv_cyc[cv_cyc.size() - 1] : 0;
      g = 0;
      while (err_cyc.size() == 0 && g < 100) begin @(negedge clk); #1; g++; end
      check("tmo_err_seen", err_cyc.size(), 1);
      if (err_cyc.size() >= 1) check("tmo_err_cycle", err_cyc[0], last_beat + TMO + 1);
      check("tmo_busy_falls", busy, 1'b0);
      repeat (4) begin @(posedge clk); #1; end
      check("tmo_single_pulse", err_cyc.size(), 1);
      check("tmo_no_m_valid", m_q.size(), 0);
      $display("[%0t] msg timeout len=5 err_pulses=%0d m_beats=%0d", $time, err_cyc.size(), m_q.size());
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_block_sequencer.md
# sha256_block_sequencer

Single-block message sequencer that sits between a byte-stream host and the `sha256_shift_reg` hashing core. It buffers a 1–55 byte message and applies SHA-256 padding: 0x80, zero fill, then the 64-bit big-endian bit length. It streams the resulting 64-byte block into the core as one contiguous burst, then forwards the core's 32-byte digest to the host with framing. Messages longer than one padded block are rejected with an error and drained.

## Interface
- `TIMEOUT_CYCLES`, default 1024: watchdog limit in WAIT; only used with `SHA_SEQ_TIMEOUT_EN`.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_data`  in  8  host message byte.
- `s_valid`  in  1  `s_data` valid.
- `s_last`  in  1  final byte of message; qualified by `s_valid`.
- `s_ready`  out  1  sequencer accepts a byte this cycle.
- `core_data`  out  8  to core `data_in`.
- `core_valid`  out  1  to core `valid_in`.
- `core_hash`  in  8  from core `hash_out`.
- `core_hash_valid`  in  1  from core `valid_o`.
- `m_hash`  out  8  digest byte, MSB byte first.
- `m_valid`  out  1  `m_hash` valid; no backpressure.
- `m_last`  out  1  marks 32nd digest byte.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  one-cycle pulse on overlength message or timeout.

## Operation
- States: IDLE, LOAD, DRAIN, FEED, WAIT, OUT.
- Byte buffer: 55 × 8 registers. Byte count `cnt` is 6 bits.
- IDLE: `s_ready`=1. An accepted byte is written to `buf[0]`, `cnt`=1. With `s_last` → FEED; otherwise → LOAD.
- LOAD: `s_ready`=1. An accepted byte is written to `buf[cnt]` and `cnt` increments.
  - Accepted with `s_last` → FEED.
  - Accepted with `cnt`==55 before the write and `s_last`=0 → the 56th byte is an overlength error: pulse `err`, → DRAIN.
- DRAIN: `s_ready`=1. Bytes are discarded until one is accepted with `s_last`, then → IDLE. The core is never driven.
- FEED: 64-beat counter `k` runs 0..63 with `core_valid`=1 every cycle. `core_data` per beat:
  - `k`<`cnt`: `buf[k]`.
  - `k`==`cnt`: 0x80.
  - `cnt`<`k`<56: 0x00.
  - `k`=56..63: bytes of `{55'b0, cnt, 3'b0}`, big-endian. Only beats 62–63 can be nonzero.
  - After beat 63 → WAIT.
- WAIT: on the first `core_hash_valid` → OUT, and that byte counts as digest byte 0.
- OUT: each `core_hash_valid` beat is registered to `m_hash`/`m_valid`. A 5-bit digest counter tracks beats. On the beat with counter 31, `m_last`=1 → IDLE. Gaps in `core_hash_valid` are tolerated.
- `s_ready`=0 in FEED, WAIT, OUT. `core_hash_valid` seen in IDLE, LOAD, DRAIN or FEED is ignored.
- Empty messages are not supported; the minimum message length is 1 byte.

## Timing
- Reset values: all outputs 0 (`s_ready`=0 during reset), state IDLE, counters 0. Buffer contents are don't-care.
- `s_ready` is 1 the first cycle after reset deassertion.
- Last host byte accepted at cycle t → `core_valid` high for cycles t+1..t+64 inclusive, with no gaps.
- Digest latency: `m_valid` at cycle c+1 for each `core_hash_valid` at cycle c.
- `err` pulses in the cycle after the offending byte is accepted.
- Reset asserted mid-operation: immediate return to IDLE; outputs drop to reset values asynchronously. A partially fed core is recovered only by the core's own reset, which is tied to the same `reset_n`.

## Configuration
- `SHA_SEQ_TIMEOUT_EN` defined:
  - A counter runs in WAIT. It aborts if no `core_hash_valid` is seen within `TIMEOUT_CYCLES` cycles after FEED ends.
  - On abort: pulse `err`, → IDLE, no `m_valid`.
  - The counter also resets on every beat in OUT, so an inter-beat gap ≥ `TIMEOUT_CYCLES` also aborts.
- Not defined: WAIT and OUT wait indefinitely; no timeout counter logic is synthesized.

## Structure
- Package `sha256_pkg` holds:
  - State enum.
  - Constants `SHA_BLOCK_BYTES`=64, `SHA_DIGEST_BYTES`=32, `SHA_MAX_MSG_BYTES`=55, `SHA_PAD_BYTE`=8'h80.
- Sub-module `sha256_pad_gen`: combinational mapping from (`k`, `cnt`, buffer byte) to the padded byte. All other logic stays flat.

## Test plan
- "abc" (0x61,0x62,0x63, last on 0x63) → 64 contiguous core beats: 61 62 63 80, 52×00, seven 00s, then 0x18. With a reference core, `m_hash` = ba 78 16 bf … f2 00 15 ad and `m_last` on 0xad.
- 55-byte message → beat 55 = 0x80, beats 56–61 = 00, beats 62–63 = 0x01 0xB8, no `err`.
- 56 bytes without `s_last`, then 3 more ending in `s_last` → `err` one pulse after byte 56, no `core_valid`, `s_ready` stays 1, IDLE afterwards.
- 1-byte message with `s_last`, host gaps between later stimuli; `core_hash_valid` asserted with 2-cycle gaps → exactly 32 `m_valid` beats, order preserved.
- Reset pulse at beat 30 of FEED → `core_valid` 0 immediately; next message after reset is processed normally.
- With `SHA_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, core silent → `err` pulse 16 cycles after FEED ends, `busy` falls, no `m_valid`.
